// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer
// Fetches halfwords from instruction memory into a small prefetch queue,
// decodes instruction length from the head halfword and presents complete
// 16/32/48-bit instructions to decode over a valid/ready handshake.
// Branch redirects flush the queue and restart fetch at the new PC.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   mem_req/mem_addr/mem_gnt       halfword read request (one outstanding)
//   mem_rvalid/mem_rdata           read response
//   redirect_i/redirect_pc_i       flush and restart fetch at new PC
//   inst_valid_o/inst_ready_i      instruction handshake to decode
//   inst_o/inst_len_o/inst_pc_o    instruction, length in halfwords, PC
//
// Fetch FSM
//   state   | meaning
//   ST_REQ  | request a halfword when the queue has room, wait for grant
//   ST_WAIT | one request outstanding, wait for its response
module ifetch_sequencer #(
  parameter int          DEPTH    = 8,
  parameter logic [24:0] RESET_PC = 25'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_i,
  input  logic [24:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [47:0] inst_o,
  output logic [1:0]  inst_len_o,
  output logic [24:0] inst_pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ST_REQ = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [24:0]   r_fetch_pc;
  logic          r_drop;
  logic [15:0]   r_q [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [24:0]   r_issue_pc;
  logic          r_inst_valid;
  logic [47:0]   r_inst;
  logic [1:0]    r_inst_len;
  logic [24:0]   r_inst_pc;

  logic [15:0]   w_h0, w_h1, w_h2;
  logic [1:0]    w_len;
  logic [47:0]   w_inst;
  logic          w_issue;
  logic          w_push;
  logic          w_grant;
  logic          w_outstanding;
  logic [CW-1:0] w_pop_n;
  logic [CW-1:0] w_count_nxt;
  logic          w_space;

  assign w_h0 = r_q[r_rd_ptr];
  assign w_h1 = r_q[r_rd_ptr + PW'(1)];
  assign w_h2 = r_q[r_rd_ptr + PW'(2)];

  always_comb begin
    w_len = 2'd2;
    if (w_h0[10:9] != 2'b11)
      w_len = 2'd1;
    else if (w_h0[15:5] == 11'b00000_110001)
      w_len = 2'd3;
  end

  always_comb begin
    w_inst = {32'd0, w_h0};
    case (w_len)
      2'd2:    w_inst = {16'd0, w_h1, w_h0};
      2'd3:    w_inst = {w_h2, w_h1, w_h0};
      default: w_inst = {32'd0, w_h0};
    endcase
  end

  // A redirect suppresses issue, push and grant bookkeeping for this edge.
  assign w_issue = !redirect_i && (r_count >= CW'(w_len)) &&
                   (!r_inst_valid || inst_ready_i);
  assign w_push  = (r_state == ST_WAIT) && mem_rvalid && !r_drop && !redirect_i;
  assign w_grant = (r_state == ST_REQ) && r_mem_req && mem_gnt;
  // A response arriving in the redirect cycle closes the outstanding request.
  assign w_outstanding = ((r_state == ST_WAIT) && !mem_rvalid) || w_grant;

  assign w_pop_n     = w_issue ? CW'(w_len) : '0;
  assign w_count_nxt = r_count + CW'(w_push) - w_pop_n;
  // Only evaluated with nothing outstanding, so occupancy alone bounds it.
  assign w_space     = w_count_nxt < CW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_REQ;
      r_mem_req    <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_drop       <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_issue_pc   <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_len   <= '0;
      r_inst_pc    <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc   <= redirect_pc_i;
      r_issue_pc   <= redirect_pc_i;
      r_inst_valid <= 1'b0;
      r_rd_ptr     <= r_wr_ptr;
      r_count      <= '0;
      if (w_outstanding) begin
        r_state   <= ST_WAIT;
        r_drop    <= 1'b1;
        r_mem_req <= 1'b0;
      end else begin
        r_state   <= ST_REQ;
        r_drop    <= 1'b0;
        r_mem_req <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_grant) begin
            r_state    <= ST_WAIT;
            r_mem_req  <= 1'b0;
            r_fetch_pc <= r_fetch_pc + 25'd1;
          end else begin
            r_mem_req <= w_space;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state   <= ST_REQ;
            r_drop    <= 1'b0;
            r_mem_req <= w_space;
          end else begin
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_REQ;
          r_mem_req <= 1'b0;
        end
      endcase

      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);

      if (w_issue) begin
        r_rd_ptr     <= r_rd_ptr + PW'(w_len);
        r_inst       <= w_inst;
        r_inst_len   <= w_len;
        r_inst_pc    <= r_issue_pc;
        r_inst_valid <= 1'b1;
        r_issue_pc   <= r_issue_pc + 25'(w_len);
      end else if (inst_ready_i) begin
        r_inst_valid <= 1'b0;
      end

      r_count <= w_count_nxt;
    end
  end

  // Queue storage carries no reset; occupancy tracking makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (w_push)
      r_q[r_wr_ptr] <= mem_rdata;
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_fetch_pc;
  assign inst_valid_o = r_inst_valid;
  assign inst_o       = r_inst;
  assign inst_len_o   = r_inst_len;
  assign inst_pc_o    = r_inst_pc;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Testbench for ifetch_sequencer: memory model with random grant/latency,
// scoreboard of expected instructions built from the memory image.
module tb_ifetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        redirect_i;
  logic [24:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [47:0] inst_o;
  logic [1:0]  inst_len_o;
  logic [24:0] inst_pc_o;

  always #5 clk = ~clk;

  ifetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_len_o    (inst_len_o),
    .inst_pc_o     (inst_pc_o)
  );

  typedef struct packed {
    logic [24:0] pc;
    logic [1:0]  len;
    logic [47:0] inst;
  } exp_t;

  logic [15:0] img [0:1023];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // memory model / driver state
  bit          pend = 0;
  int          pcnt = 0;
  logic [24:0] paddr = '0;
  bit          last_grant = 0;
  logic [24:0] last_addr = '0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100;
  bit          hold_rdy = 0;
  bit          redir_req = 0;
  logic [24:0] redir_pc = '0;
  bit          p_hold = 0;
  logic [47:0] p_inst;
  logic [1:0]  p_len;
  logic [24:0] p_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [24:0] start, input int n);
    logic [24:0] pc, p1, p2;
    logic [15:0] h0, h1, h2;
    exp_t e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      p1 = pc + 25'd1;
      p2 = pc + 25'd2;
      h0 = img[pc[9:0]];
      h1 = img[p1[9:0]];
      h2 = img[p2[9:0]];
      e.pc = pc;
      if (h0[10:9] != 2'b11)               e.len = 2'd1;
      else if (h0[15:5] == 11'h031)        e.len = 2'd3;
      else                                 e.len = 2'd2;
      if (e.len == 2'd1)      e.inst = {32'd0, h0};
      else if (e.len == 2'd2) e.inst = {16'd0, h1, h0};
      else                    e.inst = {h2, h1, h0};
      sb.push_back(e);
      pc = pc + 25'(e.len);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (last_grant) begin
      pend  = 1;
      paddr = last_addr;
      pcnt  = $urandom_range(lat_max, lat_min);
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = img[paddr[9:0]];
        pend       = 0;
      end
    end
    mem_gnt    = !pend && ($urandom_range(99, 0) < gnt_pct);
    last_grant = mem_gnt && mem_req && rst_n;
    last_addr  = mem_addr;

    redirect_i    = redir_req;
    redirect_pc_i = redir_pc;
    redir_req     = 0;
    if (redirect_i)
      inst_ready_i = 1'b1;
    else
      inst_ready_i = !hold_rdy && (sb.size() > 0) && ($urandom_range(99, 0) < rdy_pct);

    if (rst_n && p_hold) begin
      check("hold_valid", 64'(inst_valid_o), 64'd1);
      check("hold_inst", 64'(inst_o), 64'(p_inst));
      check("hold_len", 64'(inst_len_o), 64'(p_len));
      check("hold_pc", 64'(inst_pc_o), 64'(p_pc));
    end
    if (rst_n && inst_valid_o && inst_ready_i && !redirect_i) begin
      e = sb.pop_front();
      check("issue_pc", 64'(inst_pc_o), 64'(e.pc));
      check("issue_len", 64'(inst_len_o), 64'(e.len));
      check("issue_inst", 64'(inst_o), 64'(e.inst));
    end
    p_hold = rst_n && inst_valid_o && !inst_ready_i && !redirect_i;
    p_inst = inst_o;
    p_len  = inst_len_o;
    p_pc   = inst_pc_o;
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (sb.size() > 0 && c < max) begin
      step();
      c++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   64'(mem_req), 64'd0);
    check({tag, "_addr"},  64'(mem_addr), 64'd0);
    check({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
    check({tag, "_inst"},  64'(inst_o), 64'd0);
    check({tag, "_len"},   64'(inst_len_o), 64'd0);
    check({tag, "_pc"},    64'(inst_pc_o), 64'd0);
  endtask

  task automatic do_redirect(input logic [24:0] pc, input int n);
    redir_req = 1;
    redir_pc  = pc;
    sb.delete();
    step();
    push_stream(pc, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] targets [7];
    int c;
    targets = '{25'h0000020, 25'h00003F8, 25'h1FFFFFF, 25'h0000055,
                25'h0000100, 25'h0000007, 25'h1FFFFFE};

    for (int i = 0; i < 1024; i++) begin
      img[i] = 16'h8000 | 16'(i & 'h1FF);
      if (i >= 16 && i <= 250 && (i % 5) == 0)
        img[i] = 16'h0600 | 16'(i & 'hFF);
    end
    img[0] = 16'h11C1; img[1] = 16'h125F; img[2] = 16'h1EC1; img[3] = 16'h000B;
    img[4] = 16'h0631; img[5] = 16'h5678; img[6] = 16'h1234;
    img[10'h100] = 16'h1EC1; img[10'h101] = 16'hBEEF;
    img[10'h3FF] = 16'h0631;

    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;

    repeat (3) step();
    check_reset_vals("rst");
    rst_n = 1'b1;
    push_stream(25'd0, 60);
    step();
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", 64'(mem_addr), 64'd0);

    // mixed random traffic
    gnt_pct = 70; lat_min = 1; lat_max = 2; rdy_pct = 70;
    c = 0;
    while (sb.size() > 40 && c < 2000) begin step(); c++; end
    check("phase_a_timeout", 64'(sb.size() <= 40), 64'd1);

    // backpressure: queue must fill and stop requesting
    gnt_pct = 100; lat_min = 1; lat_max = 1; hold_rdy = 1;
    repeat (20) step();
    check("full_req", 64'(mem_req), 64'd0);
    check("full_valid", 64'(inst_valid_o), 64'd1);
    hold_rdy = 0; rdy_pct = 100;
    drain(2000);

    // redirect with nothing outstanding
    repeat (20) step();
    do_redirect(25'h180, 0);
    step();
    check("redir_valid_clr", 64'(inst_valid_o), 64'd0);
    check("redir_req_now", 64'(mem_req), 64'd1);
    check("redir_addr_now", 64'(mem_addr), 64'h180);

    // redirect while a request is outstanding
    lat_min = 3; lat_max = 3;
    c = 0;
    while (!(pend && pcnt >= 2) && c < 50) begin step(); c++; end
    check("pend_seen", 64'(pend), 64'd1);
    do_redirect(25'h100, 25);
    c = 0;
    while (!mem_req && c < 50) begin step(); c++; end
    check("redir_addr", 64'(mem_addr), 64'h100);
    gnt_pct = 70; lat_min = 1; lat_max = 3; rdy_pct = 70;
    drain(3000);

    // async reset mid-transfer with a response in flight
    do_redirect(25'h20, 30);
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    c = 0;
    while (sb.size() > 15 && c < 2000) begin step(); c++; end
    c = 0;
    while (!(pend && pcnt >= 2 && inst_valid_o) && c < 200) begin step(); c++; end
    check("pend_before_reset", 64'(pend && inst_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    p_hold = 0;
    sb.delete();
    step();
    rst_n = 1'b1;
    push_stream(25'd0, 30);
    step();
    check("re_req", 64'(mem_req), 64'd1);
    check("re_addr", 64'(mem_addr), 64'd0);
    lat_min = 1; lat_max = 3; gnt_pct = 70;
    drain(3000);

    // random redirects, including across the address wrap
    for (int k = 0; k < 7; k++) begin
      do_redirect(targets[k], 25);
      repeat ($urandom_range(40, 5)) step();
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
